// File: rtl/rr_sel_4_arbiter.sv
// Round-robin arbiter for a shared 2-bit 4:1 selector.
// Grants one of four requesters, caps tenure at HOLD_MAX cycles.
module rr_sel_4_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic [1:0] OUT,
  output logic       VALID
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      base;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic            own_req;
  logic            other_req;
  logic            at_max;

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] r;
    r    = 4'b0000;
    r[i] = 1'b1;
    return r;
  endfunction

  // Scan from base+1 upward; base itself ranks last.
  always_comb begin
    base     = (state_q == GRANT) ? sel_q : last_q;
    pick_any = |REQ;
    pick_idx = base;
    for (int k = 4; k >= 1; k--) begin
      if (REQ[2'(base + 2'(k))])
        pick_idx = 2'(base + 2'(k));
    end
  end

  assign own_req   = REQ[sel_q];
  assign other_req = |(REQ & ~oh(sel_q));
  assign at_max    = (cnt_q == CW'(HOLD_MAX));

  // Next-state for ownership, tenure counter and rotation pointer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = oh(pick_idx);
          cnt_d   = CW'(1);
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        unique case (1'b1)
          !own_req: begin
            last_d = sel_q;
            if (pick_any) begin
              sel_d = pick_idx;
              gnt_d = oh(pick_idx);
              cnt_d = CW'(1);
            end else begin
              state_d = IDLE;
              gnt_d   = 4'b0000;
              cnt_d   = '0;
            end
          end
          own_req && !at_max: begin
            cnt_d = cnt_q + CW'(1);
          end
          own_req && at_max && other_req: begin
            last_d = sel_q;
            sel_d  = pick_idx;
            gnt_d  = oh(pick_idx);
            cnt_d  = CW'(1);
          end
          default: begin
            cnt_d = CW'(1);
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      last_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Data mux with zero output while idle.
  always_comb begin
    VALID = (state_q == GRANT);
    OUT   = 2'b00;
    if (VALID) begin
      unique case (sel_q)
        2'b00: OUT = A;
        2'b01: OUT = B;
        2'b10: OUT = C;
        2'b11: OUT = D;
        default: OUT = 2'b00;
      endcase
    end
  end

  assign GNT = gnt_q;
  assign SEL = sel_q;

endmodule

// File: tb/tb_rr_sel_4_arbiter.sv
// Directed-vector bench for rr_sel_4_arbiter.
// Each scenario task drives stimulus and checks outputs inline.
module tb_rr_sel_4_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [1:0] A, B, C, D;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic [1:0] OUT;
  logic       VALID;

  int nvec;
  int nerr;

  rr_sel_4_arbiter #(.HOLD_MAX(4), .CW(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .GNT   (GNT),
    .SEL   (SEL),
    .OUT   (OUT),
    .VALID (VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    REQ   = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic exp_owner(string nm, logic [1:0] o, logic [1:0] d);
    logic [3:0] g;
    g    = 4'b0000;
    g[o] = 1'b1;
    nvec++;
    if (GNT !== g || SEL !== o || VALID !== 1'b1 || OUT !== d) begin
      nerr++;
      $display("FAIL %s got gnt=%b sel=%b v=%b out=%b want gnt=%b sel=%b v=1 out=%b",
               nm, GNT, SEL, VALID, OUT, g, o, d);
    end
  endtask

  task automatic exp_idle(string nm, logic [1:0] s);
    nvec++;
    if (GNT !== 4'b0000 || SEL !== s || VALID !== 1'b0 || OUT !== 2'b00) begin
      nerr++;
      $display("FAIL %s got gnt=%b sel=%b v=%b out=%b want gnt=0000 sel=%b v=0 out=00",
               nm, GNT, SEL, VALID, OUT, s);
    end
  endtask

  task automatic test_reset();
    A = 2'b01; B = 2'b10; C = 2'b11; D = 2'b00;
    apply_reset();
    exp_idle("reset", 2'b00);
    REQ = 4'b0100;
    tick();
    exp_owner("single_c", 2'b10, 2'b11);
  endtask

  task automatic test_rotation();
    logic [1:0] d [4];
    d[0] = 2'b01; d[1] = 2'b10; d[2] = 2'b11; d[3] = 2'b00;
    apply_reset();
    REQ = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_owner($sformatf("rot_%0d", k), 2'((k / 4) % 4), d[(k / 4) % 4]);
    end
  endtask

  task automatic test_release_idle();
    apply_reset();
    REQ = 4'b0001;
    tick();
    exp_owner("rel_a1", 2'b00, 2'b01);
    tick();
    exp_owner("rel_a2", 2'b00, 2'b01);
    REQ = 4'b0000;
    tick();
    exp_idle("rel_idle", 2'b00);
    tick();
    exp_idle("rel_idle2", 2'b00);
  endtask

  task automatic test_sole_hold();
    apply_reset();
    REQ = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_owner($sformatf("sole_%0d", k), 2'b01, 2'b10);
    end
    REQ = 4'b1010;
    tick();
    exp_owner("sole_hold3", 2'b01, 2'b10);
    tick();
    exp_owner("sole_hold4", 2'b01, 2'b10);
    tick();
    exp_owner("sole_force_d", 2'b11, 2'b00);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    REQ = 4'b0010;
    tick();
    exp_owner("b2b_b", 2'b01, 2'b10);
    REQ = 4'b1001;
    tick();
    exp_owner("b2b_d", 2'b11, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_owner($sformatf("b2b_dhold_%0d", k), 2'b11, 2'b00);
    end
    tick();
    exp_owner("b2b_a", 2'b00, 2'b01);
    REQ = 4'b0110;
    tick();
    exp_owner("b2b_vol_b", 2'b01, 2'b10);
  endtask

  task automatic test_async_reset();
    apply_reset();
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    exp_owner("ar_pre", 2'b01, 2'b10);
    #2;
    RST_N = 1'b0;
    #1;
    exp_idle("ar_clear", 2'b00);
    @(negedge CLK);
    RST_N = 1'b1;
    REQ   = 4'b1111;
    tick();
    exp_owner("ar_a_first", 2'b00, 2'b01);
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    RST_N = 1'b0;
    REQ   = 4'b0000;
    A = 2'b01; B = 2'b10; C = 2'b11; D = 2'b00;
    test_reset();
    test_rotation();
    test_release_idle();
    test_sole_hold();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
